// File: rtl/fft_pkg.sv
// fft_pkg: FFT state type, bit reversal and twiddle ROM generation for fft_radix2_iter.
package fft_pkg;
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  function automatic int unsigned bitrev(input int unsigned n, input int bits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((n >> i) & 32'd1);
    return r;
  endfunction
  // One twiddle entry for k < N/2, round-to-nearest, +1.0 clamped to the largest positive code
  function automatic int tw_entry(input int k, input int n_log2, input int tw_w, input bit sine);
    real ang, v, full;
    int q, top;
    full = real'(longint'(1) << (tw_w - 1));
    top = (1 << (tw_w - 1)) - 1;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << n_log2);
    v = (sine ? $sin(ang) : $cos(ang)) * full;
    q = v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return q > top ? top : q;
  endfunction
endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly a +/- W*b with W = cos - j*sin; FFT_STAGE_SCALE_EN halves both outputs.
module fft_butterfly #(
  parameter int DATA_W = 32,
  parameter int TW_W = 16
) (
  input logic signed [DATA_W-1:0] a_re,
  input logic signed [DATA_W-1:0] a_im,
  input logic signed [DATA_W-1:0] b_re,
  input logic signed [DATA_W-1:0] b_im,
  input logic signed [TW_W-1:0] w_cos,
  input logic signed [TW_W-1:0] w_sin,
  input logic bypass,
  output logic signed [DATA_W-1:0] x_re,
  output logic signed [DATA_W-1:0] x_im,
  output logic signed [DATA_W-1:0] y_re,
  output logic signed [DATA_W-1:0] y_im
);
  localparam int PW = DATA_W + TW_W;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (TW_W - 2);
  logic signed [PW-1:0] p_re, p_im;
  logic signed [DATA_W-1:0] t_re, t_im;
  logic signed [DATA_W:0] s_re, s_im, d_re, d_im;
  always_comb begin
    p_re = PW'(b_re) * PW'(w_cos) + PW'(b_im) * PW'(w_sin) + HALF;
    p_im = PW'(b_im) * PW'(w_cos) - PW'(b_re) * PW'(w_sin) + HALF;
    t_re = bypass ? b_re : DATA_W'(p_re >>> (TW_W - 1));
    t_im = bypass ? b_im : DATA_W'(p_im >>> (TW_W - 1));
    s_re = (DATA_W+1)'(a_re) + (DATA_W+1)'(t_re);
    s_im = (DATA_W+1)'(a_im) + (DATA_W+1)'(t_im);
    d_re = (DATA_W+1)'(a_re) - (DATA_W+1)'(t_re);
    d_im = (DATA_W+1)'(a_im) - (DATA_W+1)'(t_im);
`ifdef FFT_STAGE_SCALE_EN
    x_re = DATA_W'(s_re >>> 1);
    x_im = DATA_W'(s_im >>> 1);
    y_re = DATA_W'(d_re >>> 1);
    y_im = DATA_W'(d_im >>> 1);
`else
    x_re = DATA_W'(s_re);
    x_im = DATA_W'(s_im);
    y_re = DATA_W'(d_re);
    y_im = DATA_W'(d_im);
`endif
  end
endmodule

// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative radix-2 DIT FFT sharing one butterfly across load/compute/unload.
// FFT_STAGE_SCALE_EN enables a 1/2 scale on every butterfly output.
module fft_radix2_iter
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 3,
  parameter int DATA_W = 32,
  parameter int TW_W = 16
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  output logic in_ready,
  input logic signed [DATA_W-1:0] in_re,
  input logic signed [DATA_W-1:0] in_im,
  output logic out_valid,
  input logic out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic out_last,
  output logic busy
);
  localparam int N = 1 << N_LOG2;
  localparam int SW = $clog2(N_LOG2);
  state_t state, nxt;
  logic [N_LOG2-1:0] cnt, a_idx, b_idx, wa;
  logic [SW-1:0] stg;
  logic [N_LOG2-2:0] bf, msk, tw_k;
  logic in_fire, out_fire, last_bf;
  logic signed [DATA_W-1:0] mem_re [N];
  logic signed [DATA_W-1:0] mem_im [N];
  logic signed [TW_W-1:0] cos_rom [N/2];
  logic signed [TW_W-1:0] sin_rom [N/2];
  logic signed [DATA_W-1:0] x_re, x_im, y_re, y_im;

  for (genvar i = 0; i < N/2; i++) begin : g_tw
    localparam logic signed [TW_W-1:0] C = TW_W'(tw_entry(i, N_LOG2, TW_W, 1'b0));
    localparam logic signed [TW_W-1:0] S = TW_W'(tw_entry(i, N_LOG2, TW_W, 1'b1));
    assign cos_rom[i] = C;
    assign sin_rom[i] = S;
  end

  assign in_ready = state == LOAD;
  assign out_valid = state == UNLOAD;
  assign busy = state == COMPUTE;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_re = out_valid ? mem_re[cnt] : '0;
  assign out_im = out_valid ? mem_im[cnt] : '0;
  assign out_last = out_valid && cnt == '1;

  // bf holds j in its low s bits and the group number above them
  always_comb begin
    msk = ~({(N_LOG2-1){1'b1}} << stg);
    a_idx = {bf & ~msk, 1'b0} | {1'b0, bf & msk};
    b_idx = a_idx | (N_LOG2'(1) << stg);
    tw_k = (bf & msk) << (N_LOG2 - 1 - int'(stg));
    wa = N_LOG2'(bitrev(32'(cnt), N_LOG2));
    last_bf = bf == '1 && stg == SW'(N_LOG2 - 1);
    nxt = (in_fire && cnt == '1) ? COMPUTE :
          (busy && last_bf) ? UNLOAD :
          (out_fire && cnt == '1) ? LOAD : state;
  end

  fft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bf (
    .a_re(mem_re[a_idx]),
    .a_im(mem_im[a_idx]),
    .b_re(mem_re[b_idx]),
    .b_im(mem_im[b_idx]),
    .w_cos(cos_rom[tw_k]),
    .w_sin(sin_rom[tw_k]),
    .bypass(tw_k == '0),
    .x_re(x_re),
    .x_im(x_im),
    .y_re(y_re),
    .y_im(y_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt <= '0;
      stg <= '0;
      bf <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt + N_LOG2'(in_fire || out_fire);
      bf <= busy ? bf + (N_LOG2-1)'(1) : '0;
      if (busy && bf == '1) stg <= last_bf ? '0 : stg + SW'(1);
    end
  end

  // Sample store needs no reset: its contents are rewritten by every frame
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[wa] <= in_re;
      mem_im[wa] <= in_im;
    end
    if (busy) begin
      mem_re[a_idx] <= x_re;
      mem_im[a_idx] <= x_im;
      mem_re[b_idx] <= y_re;
      mem_im[b_idx] <= y_im;
    end
  end
endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter: directed frames checked against a bit-exact fixed-point FFT model and hand-computed bins.
module tb_fft_radix2_iter;
  localparam int N_LOG2 = 3;
  localparam int N = 8;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int CMP = N_LOG2 * N / 2;
  localparam int PERIOD = 2 * N + CMP + 1;
`ifdef FFT_STAGE_SCALE_EN
  localparam bit SCALED = 1'b1;
`else
  localparam bit SCALED = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [DW-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [DW-1:0] out_re, out_im;

  int errors = 0, checks = 0, cyc = 0;
  bit rnd_ready = 1'b0;
  longint tw_c [N/2], tw_s [N/2];
  longint fr [N], fi [N], m_re [N], m_im [N], rx_re [N], rx_im [N];
  logic signed [DW-1:0] exp_re_q [$], exp_im_q [$];
  int acc_q [$], lat_q [$];
  int rx_idx = 0, rx_frames = 0, busy_cnt = 0, last_busy = 0;
  bit prev_ov = 1'b0, hold = 1'b0;
  logic signed [DW-1:0] h_re, h_im;

  fft_radix2_iter #(.N_LOG2(N_LOG2), .DATA_W(DW), .TW_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint qtw(input real v);
    longint q;
    q = v >= 0.0 ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
    return q > 32767 ? 32767 : q;
  endfunction

  function automatic int rev(input int n);
    int r = 0;
    for (int i = 0; i < N_LOG2; i++) if ((n & (1 << i)) != 0) r |= 1 << (N_LOG2 - 1 - i);
    return r;
  endfunction

  // Straight textbook in-place DIT over plain arrays with the fixed-point rules applied per butterfly
  task automatic model();
    longint r [N], im [N];
    longint pr, pi, sr, si, dr, di;
    for (int n = 0; n < N; n++) begin
      r[rev(n)] = fr[n];
      im[rev(n)] = fi[n];
    end
    for (int s = 0; s < N_LOG2; s++) begin
      int h = 1 << s;
      for (int base = 0; base < N; base += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          int k = j * (N / (2 * h));
          int a = base + j;
          int b = base + j + h;
          if (k == 0) begin
            pr = r[b];
            pi = im[b];
          end else begin
            pr = wrap(wrap(r[b] * tw_c[k] + im[b] * tw_s[k] + 16384, DW + TW) >>> (TW - 1), DW);
            pi = wrap(wrap(im[b] * tw_c[k] - r[b] * tw_s[k] + 16384, DW + TW) >>> (TW - 1), DW);
          end
          sr = r[a] + pr;
          si = im[a] + pi;
          dr = r[a] - pr;
          di = im[a] - pi;
          if (SCALED) begin
            sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
          end
          r[a] = wrap(sr, DW); im[a] = wrap(si, DW);
          r[b] = wrap(dr, DW); im[b] = wrap(di, DW);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      m_re[k] = r[k];
      m_im[k] = im[k];
      exp_re_q.push_back(DW'(r[k]));
      exp_im_q.push_back(DW'(im[k]));
    end
  endtask

  task automatic send(input bit gaps);
    for (int n = 0; n < N; n++) begin
      int t = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      in_re = DW'(fr[n]);
      in_im = DW'(fi[n]);
      in_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (in_ready || t > 200) break;
        t++;
      end
      chk("in_accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (rx_frames < target && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("frames_done", rx_frames, target);
  endtask

  task automatic fill(input int kind);
    for (int n = 0; n < N; n++) begin
      fi[n] = 0;
      case (kind)
        0: fr[n] = n == 0 ? 1000 : 0;
        1: fr[n] = 100;
        2: fr[n] = n % 2 == 0 ? 100 : -100;
        3: fr[n] = n == 1 ? 1000 : 0;
        default: begin
          fr[n] = longint'($urandom_range(0, 2097152)) - 1048576;
          fi[n] = longint'($urandom_range(0, 2097152)) - 1048576;
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (busy) begin
      busy_cnt++;
      last_busy = cyc;
    end
    if (out_valid && !prev_ov) lat_q.push_back(cyc - last_busy);
    prev_ov = out_valid;
    if (out_valid) begin
      chk($sformatf("out_last[%0d]", rx_idx), out_last, rx_idx == N - 1);
      if (hold) begin
        chk($sformatf("hold_re[%0d]", rx_idx), out_re, h_re);
        chk($sformatf("hold_im[%0d]", rx_idx), out_im, h_im);
      end
      if (out_ready) begin
        if (exp_re_q.size() == 0) chk("unexpected_bin", 1, 0);
        else begin
          chk($sformatf("bin_re[%0d]", rx_idx), out_re, exp_re_q.pop_front());
          chk($sformatf("bin_im[%0d]", rx_idx), out_im, exp_im_q.pop_front());
        end
        rx_re[rx_idx] = out_re;
        rx_im[rx_idx] = out_im;
        if (rx_idx == N - 1) begin
          rx_idx = 0;
          rx_frames++;
        end else rx_idx++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        h_re = out_re;
        h_im = out_im;
      end
    end else hold = 1'b0;
  end

  initial begin
    int base, b0, fexp;
    for (int k = 0; k < N / 2; k++) begin
      tw_c[k] = qtw($cos(2.0 * 3.14159265358979323846 * k / N) * 32768.0);
      tw_s[k] = qtw($sin(2.0 * 3.14159265358979323846 * k / N) * 32768.0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fexp = 0;

    fill(0); model(); send(0); wait_frames(++fexp);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("impulse_re[%0d]", k), rx_re[k], SCALED ? 125 : 1000);
      chk($sformatf("impulse_im[%0d]", k), rx_im[k], 0);
    end
    fill(1); model(); send(0); wait_frames(++fexp);
    for (int k = 0; k < N; k++) chk($sformatf("dc_re[%0d]", k), rx_re[k], k == 0 ? (SCALED ? 100 : 800) : 0);
    fill(2); model(); send(0); wait_frames(++fexp);
    for (int k = 0; k < N; k++) chk($sformatf("alt_re[%0d]", k), rx_re[k], k == 4 ? (SCALED ? 100 : 800) : 0);
    fill(3); model(); send(0); wait_frames(++fexp);
    if (!SCALED) begin
      chk("model_x1_re", m_re[1], 707);
      chk("model_x1_im", m_im[1], -707);
      chk("shift_x0_re", rx_re[0], 1000); chk("shift_x0_im", rx_im[0], 0);
      chk("shift_x2_re", rx_re[2], 0); chk("shift_x2_im", rx_im[2], -1000);
      chk("shift_x4_re", rx_re[4], -1000); chk("shift_x4_im", rx_im[4], 0);
      chk("shift_x6_re", rx_re[6], 0); chk("shift_x6_im", rx_im[6], 1000);
    end

    base = acc_q.size();
    b0 = busy_cnt;
    fill(4); model(); send(0);
    fill(4); model(); send(0);
    fexp += 2;
    wait_frames(fexp);
    chk("frame_period", acc_q[base + N] - acc_q[base] + 1, PERIOD);
    chk("compute_cycles", busy_cnt - b0, 2 * CMP);
    chk("first_out_latency", lat_q[lat_q.size() - 1], 1);

    rnd_ready = 1'b1;
    fill(4); model(); send(1); wait_frames(++fexp);
    fill(3); model(); send(1); wait_frames(++fexp);
    rnd_ready = 1'b0;

    fill(4); model(); send(0);
    begin
      int t = 0;
      while (!busy && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("busy_seen", busy, 1);
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    exp_re_q.delete();
    exp_im_q.delete();
    rx_idx = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(1); model(); send(0); wait_frames(++fexp);
    chk("post_rst_dc", rx_re[0], SCALED ? 100 : 800);
    chk("queue_drained", exp_re_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_radix2_iter.md
# fft_radix2_iter

Iterative radix-2 decimation-in-time FFT core, parametrised in point count and sample width. It replaces fixed 8-point combinational transforms with a single shared butterfly, a register-file sample store and a valid/ready streaming interface. Frames are loaded in natural order, transformed in place, then unloaded in natural order. It sits between the sample front-end and the spectral post-processing in the signal-processing chain.

## Interface
- N_LOG2, 3: log2 of transform length N (N = 8 by default); legal range 2..10.
- DATA_W, 32: signed width of each real/imaginary sample, input and output.
- TW_W, 16: signed twiddle width, format Q1.(TW_W-1).
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepts input (LOAD state).
- in_re, in_im  in  DATA_W each  signed input sample.
- out_valid  out  1  output bin valid (UNLOAD state).
- out_ready  in  1  downstream accepts bin.
- out_re, out_im  out  DATA_W each  signed output bin X[k].
- out_last  out  1  high with bin k = N-1.
- busy  out  1  high in COMPUTE.

## Operation
- States: LOAD, COMPUTE, UNLOAD. Reset state is LOAD.
- in_ready = (state == LOAD). out_valid = (state == UNLOAD). busy = (state == COMPUTE).
- LOAD:
  - Each in_valid && in_ready handshake writes sample n to address bitrev(n); n counts 0..N-1.
  - The handshake at n = N-1 moves the core to COMPUTE.
- COMPUTE:
  - Stages s = 0..N_LOG2-1; N/2 butterflies per stage; one butterfly per cycle; read and write-back happen in the same cycle.
  - Butterfly pair: span = 2^s. Top a = group·2^(s+1) + j, bottom b = a + span. Twiddle index k = j·(N / 2^(s+1)).
  - a' = a + W^k·b, b' = a − W^k·b, where W^k = cos(2πk/N) − j·sin(2πk/N).
  - When the last butterfly of the last stage completes, the core moves to UNLOAD.
- UNLOAD:
  - Presents X[k] for k = 0..N-1 in natural order. k advances only on out_valid && out_ready.
  - The handshake at k = N-1 returns the core to LOAD.
- Arithmetic:
  - Complex product is computed at DATA_W+TW_W bits, rounded half-up (add 2^(TW_W-2), arithmetic shift right TW_W-1), then truncated to DATA_W.
  - k = 0 bypasses the multiplier; the product is exactly b.
  - Add and subtract results wrap at DATA_W; there is no saturation.
- Boundaries:
  - in_valid is ignored outside LOAD. out_ready is ignored outside UNLOAD.
  - out_re, out_im and out_last hold stable while out_valid && !out_ready.
  - Frames never overlap: a new frame is accepted only after the last bin handshake.
  - Reset asserted at any time aborts the frame. The core returns to LOAD and clears all counters; the sample store contents are don't-care.

## Timing
- Reset values: in_ready = 1, out_valid = 0, busy = 0, out_last = 0, out_re = out_im = 0, all counters 0.
- LOAD takes N accepted samples. COMPUTE takes exactly N_LOG2·N/2 cycles (12 for N = 8).
- First out_valid appears one cycle after the final COMPUTE cycle.
- in_ready rises the cycle after the out_last handshake.
- With continuous valid/ready, frame period is 2N + N_LOG2·N/2 + 1 cycles (29 for N = 8).

## Configuration
- FFT_STAGE_SCALE_EN defined: every butterfly output is arithmetic-shifted right by 1 (floor) before write-back. The total scale is 1/N, which prevents growth overflow.
- FFT_STAGE_SCALE_EN undefined: no scaling; output equals the unnormalised DFT, subject to wrap.

## Structure
- Package fft_pkg holds:
  - state enum type;
  - bitrev function;
  - twiddle ROM generator function, which builds N/2 cos/sin entries at elaboration using round-to-nearest and clamps +1.0 to 2^(TW_W-1)−1.
- Sub-module fft_butterfly: combinational complex multiply, rounding, add/subtract and optional scale. Parameters are DATA_W and TW_W.
- Top level holds the FSM, counters, sample register file and twiddle ROM.

## Test plan
All scenarios use N_LOG2 = 3, DATA_W = 32, TW_W = 16, unscaled unless stated.
- Impulse x = [1000, 0, …, 0] → all eight bins = (1000, 0). With FFT_STAGE_SCALE_EN → (125, 0).
- DC x[n] = (100, 0) for all n → X[0] = (800, 0); X[1..7] = (0, 0).
- Alternating x[n] = (±100, 0), starting +100 → X[4] = (800, 0); all other bins (0, 0).
- Shifted impulse x[1] = 1000, rest 0 → X[0] = (1000, 0), X[2] = (0, −1000), X[4] = (−1000, 0), X[6] = (0, 1000).
- Random out_ready toggling plus in_valid gaps → bin order and values identical to the ungated run; out_last only on the 8th bin; frame period 29 cycles when both sides are always ready.
- rst_n pulsed low mid-COMPUTE → busy = 0 and in_ready = 1 immediately. The next full frame gives correct results.
